// File: rtl/exp_decoder16_seq.sv
// ---------------------------------------------------------------------------
// exp_decoder16_seq
//
// Purpose:
//   Queued 4-to-16 one-hot decoder. Binary codes are pushed into a small
//   FIFO. An output sequencer pops them one at a time and presents each code
//   as a registered one-hot word for HOLD enabled cycles. Codes that are
//   already waiting are presented back-to-back, with no idle gap between
//   them.
//
// Parameters:
//   HOLD   cycles each one-hot word stays asserted (1..15)
//   DEPTH  number of queue entries (2, 4 or 8)
//
// Ports:
//   Clk         in   single clock, rising edge
//   Rst_n       in   asynchronous active-low reset
//   En          in   output-side enable; low freezes the sequencer
//   Din[3:0]    in   code to decode
//   Din_valid   in   Din holds a code offered for acceptance
//   Din_ready   out  queue has room (Count < DEPTH); combinational
//   Dout[15:0]  out  registered one-hot word, zero when idle
//   Dout_valid  out  Dout holds a live one-hot word
//   Count[3:0]  out  number of queued codes
//
// Sequencer states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | Dout is zero; pop the head code as soon as En=1, Count>0
//   S_ACTIVE | Dout shows a code; hold_q counts remaining extra cycles
// ---------------------------------------------------------------------------
module exp_decoder16_seq #(
  parameter int unsigned HOLD  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        En,
  input  logic [3:0]  Din,
  input  logic        Din_valid,
  output logic        Din_ready,
  output logic [15:0] Dout,
  output logic        Dout_valid,
  output logic [3:0]  Count
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DEPTH_C = 4'(DEPTH);
  localparam logic [3:0]  HOLD_M1 = 4'(HOLD - 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [3:0]    hold_q, hold_d;
  logic [15:0]   dout_q, dout_d;
  logic          valid_q, valid_d;
  logic [3:0]    count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [3:0]    mem_q [DEPTH];

  logic          push;
  logic          pop;
  logic          load;
  logic [3:0]    head_code;

  // -------------------------------------------------------------------------
  // Queue side
  // -------------------------------------------------------------------------
  // Readiness looks only at the registered count, so a full queue refuses a
  // code even in a cycle where the sequencer is about to pop.
  assign Din_ready = (count_q < DEPTH_C);
  assign push      = Din_valid & Din_ready;
  assign head_code = mem_q[rptr_q];

  // DEPTH is a power of two, so the natural PW-bit wrap is the modulo.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset: occupancy is tracked entirely by the pointers
  // and count, so stale entries are never visible.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wptr_q] <= Din;
    end
  end

  // -------------------------------------------------------------------------
  // Output sequencer
  // -------------------------------------------------------------------------
  // The pop decision uses count_q, which excludes any code being written on
  // the same edge, so a freshly pushed code cannot bypass the queue.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    load    = 1'b0;

    if (En) begin
      unique case (state_q)
        S_IDLE: begin
          if (count_q != 4'd0) begin
            load = 1'b1;
          end
        end
        S_ACTIVE: begin
          if (hold_q != 4'd0) begin
            hold_d = hold_q - 4'd1;
          end else if (count_q != 4'd0) begin
            load = 1'b1;
          end else begin
            dout_d  = 16'd0;
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (load) begin
      dout_d  = 16'd1 << head_code;
      valid_d = 1'b1;
      hold_d  = HOLD_M1;
      state_d = S_ACTIVE;
    end
  end

  assign pop = load;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= 4'd0;
      dout_q  <= 16'd0;
      valid_q <= 1'b0;
      count_q <= 4'd0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  assign Dout       = dout_q;
  assign Dout_valid = valid_q;
  assign Count      = count_q;

endmodule

// File: tb/tb_exp_decoder16_seq.sv
module tb_exp_decoder16_seq;

  localparam int NI = 3;
  localparam int QD = 4;
  localparam int HOLDS [NI] = '{2, 1, 4};

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  din;
  logic        din_valid;
  logic        din_ready  [NI];
  logic [15:0] dout       [NI];
  logic        dout_valid [NI];
  logic [3:0]  count      [NI];

  int checks   = 0;
  int failures = 0;

  exp_decoder16_seq #(.HOLD(2), .DEPTH(4)) u0 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .Din(din), .Din_valid(din_valid),
    .Din_ready(din_ready[0]), .Dout(dout[0]), .Dout_valid(dout_valid[0]),
    .Count(count[0]));
  exp_decoder16_seq #(.HOLD(1), .DEPTH(4)) u1 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .Din(din), .Din_valid(din_valid),
    .Din_ready(din_ready[1]), .Dout(dout[1]), .Dout_valid(dout_valid[1]),
    .Count(count[1]));
  exp_decoder16_seq #(.HOLD(4), .DEPTH(4)) u2 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .Din(din), .Din_valid(din_valid),
    .Din_ready(din_ready[2]), .Dout(dout[2]), .Dout_valid(dout_valid[2]),
    .Count(count[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a queue of codes plus "which code is shown and for
  // how many more enabled cycles".
  int mq    [NI][QD];
  int mhead [NI];
  int msize [NI];
  int mcur  [NI];
  int mrem  [NI];
  bit mshow [NI];

  always @(posedge clk or negedge rst_n) begin
    bit accept;
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        mhead[k] = 0; msize[k] = 0; mcur[k] = 0; mrem[k] = 0; mshow[k] = 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        accept = din_valid && (msize[k] < QD);
        if (en) begin
          if (mshow[k] && mrem[k] > 1) begin
            mrem[k] = mrem[k] - 1;
          end else if (msize[k] > 0) begin
            mcur[k]  = mq[k][mhead[k]];
            mhead[k] = (mhead[k] + 1) % QD;
            msize[k] = msize[k] - 1;
            mrem[k]  = HOLDS[k];
            mshow[k] = 1;
          end else begin
            mshow[k] = 0;
          end
        end
        if (accept) begin
          mq[k][(mhead[k] + msize[k]) % QD] = int'(din);
          msize[k] = msize[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] exp_d;
    for (int k = 0; k < NI; k++) begin
      exp_d = mshow[k] ? (16'd1 << mcur[k]) : 16'd0;
      check($sformatf("model_dout[%0d]", k), 32'(dout[k]), 32'(exp_d));
      check($sformatf("model_valid[%0d]", k), 32'(dout_valid[k]), 32'(mshow[k]));
      check($sformatf("model_count[%0d]", k), 32'(count[k]), 32'(msize[k]));
      check($sformatf("model_ready[%0d]", k), 32'(din_ready[k]), 32'(msize[k] < QD));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = 4'd0;
    en        = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    int i, nrec, acc, vis, bad, np;
    bit saw_full;
    logic [15:0] rec [$];
    logic [15:0] prev;
    logic [15:0] expseq [4];
    int codes [16];

    rst_n = 1'b0; en = 1'b1; din = 4'd0; din_valid = 1'b0;

    // Reset state
    do_reset();
    #1;
    check("rst_dout", 32'(dout[0]), 32'h0);
    check("rst_valid", 32'(dout_valid[0]), 32'h0);
    check("rst_count", 32'(count[0]), 32'h0);
    check("rst_ready", 32'(din_ready[0]), 32'h1);

    // Single code 9, HOLD=1 instance (u1)
    do_reset();
    din = 4'd9; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("single_n_dout", 32'(dout[1]), 32'h0);
    check("single_n_count", 32'(count[1]), 32'h1);
    tick();
    check("single_n1_dout", 32'(dout[1]), 32'h0200);
    check("single_n1_valid", 32'(dout_valid[1]), 32'h1);
    tick();
    check("single_n2_dout", 32'(dout[1]), 32'h0);
    check("single_n2_valid", 32'(dout_valid[1]), 32'h0);
    check("single_hold2_dout", 32'(dout[0]), 32'h0200);
    repeat (6) tick();

    // En dropped mid-hold, HOLD=4 instance (u2)
    do_reset();
    din = 4'd3; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    vis = 0; bad = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (dout_valid[2]) begin
        vis++;
        if (dout[2] !== 16'h0008) bad++;
      end
      if (t == 2) en = 1'b0;
      if (t == 5) en = 1'b1;
    end
    check("enfreeze_cycles", 32'(vis), 32'd7);
    check("enfreeze_value_bad", 32'(bad), 32'd0);

    // Sweep 0..15, HOLD=2 instance (u0)
    do_reset();
    i = 0; saw_full = 0; rec.delete();
    for (int cyc = 0; cyc < 120 && rec.size() < 32; cyc++) begin
      din = 4'(i);
      din_valid = (i < 16);
      acc = int'(din_valid && din_ready[0]);
      if (!din_ready[0] && count[0] == 4'd4) saw_full = 1;
      tick();
      if (acc != 0) i++;
      if (dout_valid[0] || rec.size() > 0) rec.push_back(dout[0]);
    end
    din_valid = 1'b0;
    nrec = rec.size();
    check("sweep_len", 32'(nrec), 32'd32);
    for (int j = 0; j < 32 && j < nrec; j++)
      check($sformatf("sweep_word%0d", j), 32'(rec[j]), 32'(16'd1 << (j / 2)));
    check("sweep_full_seen", 32'(saw_full), 32'd1);
    repeat (40) tick();

    // Full queue with En=0, then drain in order
    do_reset();
    en = 1'b0;
    codes[0] = 5; codes[1] = 10; codes[2] = 15; codes[3] = 0;
    for (int j = 0; j < 4; j++) begin
      din = 4'(codes[j]); din_valid = 1'b1;
      tick();
    end
    din = 4'd7; din_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("full_ready", 32'(din_ready[0]), 32'h0);
      check("full_count", 32'(count[0]), 32'd4);
      check("full_dout", 32'(dout[0]), 32'h0);
    end
    din_valid = 1'b0; en = 1'b1;
    expseq[0] = 16'h0020; expseq[1] = 16'h0400; expseq[2] = 16'h8000; expseq[3] = 16'h0001;
    rec.delete(); prev = 16'h0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (dout_valid[0] && dout[0] != prev) rec.push_back(dout[0]);
      prev = dout[0];
    end
    check("drain_len", 32'(rec.size()), 32'd4);
    for (int j = 0; j < 4 && j < rec.size(); j++)
      check($sformatf("drain_word%0d", j), 32'(rec[j]), 32'(expseq[j]));

    // Reset while ACTIVE with Count=2
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      din = 4'(c); din_valid = 1'b1;
      tick();
    end
    check("prerst_count", 32'(count[0]), 32'd2);
    check("prerst_dout", 32'(dout[0]), 32'h0002);
    din = 4'd4; din_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dout", 32'(dout[0]), 32'h0);
    check("midrst_valid", 32'(dout_valid[0]), 32'h0);
    check("midrst_count", 32'(count[0]), 32'h0);
    check("midrst_ready", 32'(din_ready[0]), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    check("inrst_count", 32'(count[0]), 32'h0);
    #2 rst_n = 1'b1;
    din_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("postrst_valid", 32'(dout_valid[0]), 32'h0);
      check("postrst_count", 32'(count[0]), 32'h0);
    end

    // Simultaneous push/pop at Count=2 across pointer wrap
    do_reset();
    for (int j = 0; j < 16; j++) codes[j] = (j * 5 + 2) % 16;
    np = 0;
    for (int t = 1; t <= 16; t++) begin
      din_valid = (t <= 3) || ((t % 2 == 0) && t <= 14);
      din = 4'(codes[np]);
      acc = int'(din_valid && din_ready[0]);
      tick();
      if (acc != 0) np++;
      if (t >= 3 && t <= 14) check($sformatf("pushpop_count_t%0d", t), 32'(count[0]), 32'd2);
    end
    din_valid = 1'b0;
    check("pushpop_pushed", 32'(np), 32'd9);
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
